instr_prefetch_buffer: RTL and testbench

INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

---
 rtl/instr_prefetch_buffer.sv | 160 ++++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : instr_prefetch_buffer
//  Purpose  : Instruction prefetch queue between the fetch stage and an
//             in-order, pipelined instruction memory port. Keeps up to
//             MAX_OUTSTANDING requests in flight and buffers up to FIFO_DEPTH
//             response words, each tagged with its address and bus error.
//             A redirect flushes the buffer and discards stale in-flight
//             responses.
//  Ports    : clk, rstn              - clock, async active-low reset
//             redirect_i/_addr_i     - pipeline PC change and its target
//             mem_req_o/gnt_i/addr_o - request handshake to memory
//             mem_rvalid_i/rdata_i/err_i - in-order memory responses
//             out_valid_o/ready_i    - buffered word handshake to fetch
//             out_rdata_o/addr_o/err_o - head word, its address and error
//             busy_o                 - at least one request outstanding
//  Revision : 1.0 - initial release
// ============================================================================
module instr_prefetch_buffer #(
  parameter logic [31:0] PC_RESET        = 32'h0,
  parameter int unsigned FIFO_DEPTH      = 3,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o,
  output logic        busy_o
);

  localparam int unsigned c_cnt_w = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned c_ptr_w = $clog2(FIFO_DEPTH);

  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_max_out   = c_cnt_w'(MAX_OUTSTANDING);
  localparam logic [c_cnt_w:0]   c_depth_ext = (c_cnt_w + 1)'(FIFO_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_last  = c_ptr_w'(FIFO_DEPTH - 1);
  localparam logic [31:0]        c_boot_addr = {PC_RESET[31:2], 2'b00};

  // Entry layout: {rdata[64:33], addr[32:1], err[0]}
  logic [64:0]        r_entry [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_fifo_count;
  logic [c_cnt_w-1:0] r_outstanding;
  logic [c_cnt_w-1:0] r_discard_cnt;
  logic [31:0]        r_fetch_addr;
  logic [31:0]        r_resp_addr;

  logic               w_grant;
  logic               w_push;
  logic               w_drop;
  logic               w_pop;
  logic [c_cnt_w:0]   w_credit_used;
  logic [c_cnt_w-1:0] w_outstanding_nxt;
  logic [31:0]        w_redirect_addr;
  logic [64:0]        w_head;
  logic               w_unused;

  // Low address bits are ignored by design.
  assign w_unused        = ^redirect_addr_i[1:0];
  assign w_redirect_addr = {redirect_addr_i[31:2], 2'b00};

  // Credits: every in-flight request (stale ones included) reserves a FIFO
  // slot, so a response can never arrive to a full buffer.
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, r_fifo_count};
  assign mem_req_o     = ~redirect_i & (r_outstanding < c_max_out) &
                         (w_credit_used < c_depth_ext);
  assign mem_addr_o    = {r_fetch_addr[31:2], 2'b00};
  assign busy_o        = (r_outstanding != '0);

  assign w_grant = mem_req_o & mem_gnt_i;
  assign w_push  = mem_rvalid_i & ~redirect_i & (r_discard_cnt == '0);
  assign w_drop  = mem_rvalid_i & ~redirect_i & (r_discard_cnt != '0);
  assign w_pop   = out_valid_o & out_ready_i & ~redirect_i;

  assign out_valid_o = (r_fifo_count != '0);
  assign w_head      = r_entry[r_rd_ptr];
  assign out_rdata_o = w_head[64:33];
  assign out_addr_o  = w_head[32:1];
  assign out_err_o   = w_head[0];

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_last) ? '0 : p + c_ptr_one;
  endfunction

  always_comb begin
    w_outstanding_nxt = r_outstanding;
    if (w_grant && !mem_rvalid_i) begin
      w_outstanding_nxt = r_outstanding + c_cnt_one;
    end else if (!w_grant && mem_rvalid_i && (r_outstanding != '0)) begin
      w_outstanding_nxt = r_outstanding - c_cnt_one;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fetch_addr  <= c_boot_addr;
      r_resp_addr   <= c_boot_addr;
      r_outstanding <= '0;
      r_discard_cnt <= '0;
      r_fifo_count  <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (redirect_i) begin
        // No grant is possible this cycle, and a response arriving now has
        // already been removed from w_outstanding_nxt, so everything still
        // in flight afterwards is stale.
        r_fetch_addr  <= w_redirect_addr;
        r_resp_addr   <= w_redirect_addr;
        r_discard_cnt <= w_outstanding_nxt;
        r_fifo_count  <= '0;
        r_wr_ptr      <= '0;
        r_rd_ptr      <= '0;
      end else begin
        if (w_grant) begin
          r_fetch_addr <= r_fetch_addr + 32'd4;
        end
        if (w_drop) begin
          r_discard_cnt <= r_discard_cnt - c_cnt_one;
        end
        if (w_push) begin
          r_resp_addr <= r_resp_addr + 32'd4;
          r_wr_ptr    <= ptr_inc(r_wr_ptr);
        end
        if (w_pop) begin
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
        if (w_push && !w_pop) begin
          r_fifo_count <= r_fifo_count + c_cnt_one;
        end else if (w_pop && !w_push) begin
          r_fifo_count <= r_fifo_count - c_cnt_one;
        end
      end
    end
  end

  // Data storage carries no reset; contents only matter while valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_entry[r_wr_ptr] <= {mem_rdata_i, r_resp_addr, mem_err_i};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_prefetch_buffer
//  Purpose  : Directed scoreboard bench for instr_prefetch_buffer. A driver
//             applies stimulus and models an in-order memory with one cycle
//             response latency; a monitor pops expected words whenever fetch
//             consumes a buffered word.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = '0;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_err_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_err_o;
  logic        busy_o;

  instr_prefetch_buffer #(
    .PC_RESET       (32'h100),
    .FIFO_DEPTH     (3),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .redirect_i     (redirect_i),
    .redirect_addr_i(redirect_addr_i),
    .mem_req_o      (mem_req_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_addr_o     (mem_addr_o),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_err_i      (mem_err_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_rdata_o    (out_rdata_o),
    .out_addr_o     (out_addr_o),
    .out_err_o      (out_err_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        err;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        exp_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] grant_log[$];

  // Per-cycle stimulus, applied at the next falling edge.
  logic        s_redir = 1'b0;
  logic [31:0] s_raddr = '0;
  logic        s_gnt   = 1'b0;
  logic        s_ready = 1'b0;
  logic        s_hold  = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic chk_grant(input int idx, input logic [31:0] want);
    if (idx < grant_log.size()) begin
      check($sformatf("grant_addr[%0d]", idx), grant_log[idx], want);
    end else begin
      total++;
      bad++;
      $display("FAIL grant_missing[%0d]: got none want %h", idx, want);
    end
  endtask

  task automatic expect_word(input logic [31:0] a, input logic e);
    exp_t x;
    x.addr = a;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  // One clock cycle: drive inputs, return a memory response for the oldest
  // granted request, then record whether this cycle grants a new one.
  task automatic cyc();
    logic [31:0] a;
    @(negedge clk);
    redirect_i      = s_redir;
    redirect_addr_i = s_raddr;
    mem_gnt_i       = s_gnt;
    out_ready_i     = s_ready;
    if (!s_hold && pend_q.size() != 0) begin
      a            = pend_q.pop_front();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mdata(a);
      mem_err_i    = (a == err_addr);
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      mem_err_i    = 1'b0;
    end
    #1;
    if (mem_req_o && mem_gnt_i) begin
      pend_q.push_back(mem_addr_o);
      grant_log.push_back(mem_addr_o);
    end
  endtask

  task automatic drain_check(input string name);
    #3;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rstn = 1'b0;
    redirect_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    mem_err_i = 1'b0; out_ready_i = 1'b0;
    s_redir = 1'b0; s_gnt = 1'b0; s_ready = 1'b0; s_hold = 1'b0;
    err_addr = 32'hFFFF_FFFF;
    pend_q.delete();
    exp_q.delete();
    grant_log.delete();
    if (chk) begin
      #1;
      check("rst_mid_mem_req", {31'b0, mem_req_o}, 32'd1);
      check("rst_mid_busy", {31'b0, busy_o}, 32'd0);
      check("rst_mid_out_valid", {31'b0, out_valid_o}, 32'd0);
      check("rst_mid_addr", mem_addr_o, 32'h100);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Monitor: every consumed word must be the next expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rstn && out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got addr %h want none", out_addr_o);
        end else begin
          e = exp_q.pop_front();
          check("sb_addr", out_addr_o, e.addr);
          check("sb_data", out_rdata_o, mdata(e.addr));
          check("sb_err", {31'b0, out_err_o}, {31'b0, e.err});
        end
      end
    end
  end

  initial begin
    // Power-on reset
    #1 rstn = 1'b0;
    #1;
    check("rst_mem_req", {31'b0, mem_req_o}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_addr", mem_addr_o, 32'h100);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Boot streaming: six grants, one word per cycle
    s_gnt = 1'b1; s_ready = 1'b1;
    for (int i = 0; i < 6; i++) expect_word(32'h100 + 32'(4 * i), 1'b0);
    cyc();
    chk_grant(0, 32'h100);
    cyc();
    check("boot_not_early", {31'b0, out_valid_o}, 32'd0);
    cyc();
    check("boot_latency_valid", {31'b0, out_valid_o}, 32'd1);
    check("boot_latency_addr", out_addr_o, 32'h100);
    repeat (3) cyc();
    s_gnt = 1'b0;
    repeat (5) cyc();
    check("boot_grants", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk_grant(i, 32'h100 + 32'(4 * i));
    drain_check("boot_drain");

    // Backpressure: credits stop requests after three grants
    do_reset(1'b0);
    s_gnt = 1'b1; s_ready = 1'b0;
    repeat (10) cyc();
    check("bp_grants", 32'(grant_log.size()), 32'd3);
    check("bp_req_low", {31'b0, mem_req_o}, 32'd0);
    check("bp_busy", {31'b0, busy_o}, 32'd0);
    check("bp_head_valid", {31'b0, out_valid_o}, 32'd1);
    check("bp_head_addr", out_addr_o, 32'h100);
    expect_word(32'h100, 1'b0);
    expect_word(32'h104, 1'b0);
    expect_word(32'h108, 1'b0);
    s_gnt = 1'b0; s_ready = 1'b1;
    repeat (5) cyc();
    drain_check("bp_drain");

    // Redirect with two stale responses in flight
    do_reset(1'b0);
    s_gnt = 1'b1; s_ready = 1'b1; s_hold = 1'b1;
    cyc();
    cyc();
    check("rd2_busy", {31'b0, busy_o}, 32'd1);
    s_redir = 1'b1; s_raddr = 32'h2002;
    cyc();
    check("rd2_req_in_redirect", {31'b0, mem_req_o}, 32'd0);
    s_redir = 1'b0; s_hold = 1'b0;
    expect_word(32'h2000, 1'b0);
    expect_word(32'h2004, 1'b0);
    expect_word(32'h2008, 1'b0);
    cyc();
    check("rd2_valid_after", {31'b0, out_valid_o}, 32'd0);
    check("rd2_req_no_credit", {31'b0, mem_req_o}, 32'd0);
    cyc();
    check("rd2_restart_req", {31'b0, mem_req_o}, 32'd1);
    check("rd2_restart_addr", mem_addr_o, 32'h2000);
    cyc();
    cyc();
    s_gnt = 1'b0;
    repeat (5) cyc();
    check("rd2_grants", 32'(grant_log.size()), 32'd5);
    chk_grant(2, 32'h2000);
    drain_check("rd2_drain");

    // Redirect coinciding with the only response
    do_reset(1'b0);
    s_gnt = 1'b1; s_ready = 1'b1;
    cyc();
    s_gnt = 1'b0; s_redir = 1'b1; s_raddr = 32'h2000;
    cyc();
    s_redir = 1'b0; s_gnt = 1'b1;
    expect_word(32'h2000, 1'b0);
    cyc();
    check("rd1_busy", {31'b0, busy_o}, 32'd0);
    check("rd1_valid", {31'b0, out_valid_o}, 32'd0);
    check("rd1_addr", mem_addr_o, 32'h2000);
    s_gnt = 1'b0;
    repeat (4) cyc();
    drain_check("rd1_drain");

    // Bus error on 0x104 only
    do_reset(1'b0);
    err_addr = 32'h104;
    s_gnt = 1'b1; s_ready = 1'b1;
    expect_word(32'h100, 1'b0);
    expect_word(32'h104, 1'b1);
    expect_word(32'h108, 1'b0);
    repeat (3) cyc();
    s_gnt = 1'b0;
    repeat (5) cyc();
    drain_check("err_drain");

    // Address wrap, then reset in the middle of the burst
    do_reset(1'b0);
    s_gnt = 1'b1; s_ready = 1'b1; s_redir = 1'b1; s_raddr = 32'hFFFF_FFF8;
    cyc();
    s_redir = 1'b0;
    expect_word(32'hFFFF_FFF8, 1'b0);
    expect_word(32'hFFFF_FFFC, 1'b0);
    repeat (4) cyc();
    chk_grant(0, 32'hFFFF_FFF8);
    chk_grant(1, 32'hFFFF_FFFC);
    chk_grant(2, 32'h0000_0000);
    chk_grant(3, 32'h0000_0004);
    drain_check("wrap_drain");
    do_reset(1'b1);
    s_gnt = 1'b1; s_ready = 1'b1;
    expect_word(32'h100, 1'b0);
    cyc();
    chk_grant(0, 32'h100);
    s_gnt = 1'b0;
    repeat (4) cyc();
    drain_check("restart_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
